// File: rtl/add64_scheduler.sv
// 64-bit adder service for two requesters, time-sharing one 32-bit carry-select adder.
// Each request runs a low pass, a high pass and, only when the low half carries, an increment pass.

module CSelA32 (
   output logic [31:0] sum,
   output logic        cout,
   input  logic [31:0] a,
   input  logic [31:0] b
);

   localparam int BLK  = 8;
   localparam int NBLK = 4;

   logic [NBLK:0] carry;

   assign carry[0] = 1'b0;

   // Each byte precomputes its result for both possible carry-ins; the incoming carry only selects.
   for (genvar g = 0; g < NBLK; g++) begin : g_blk
      logic [BLK:0] s_c0;
      logic [BLK:0] s_c1;

      assign s_c0 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]};
      assign s_c1 = {1'b0, a[g*BLK +: BLK]} + {1'b0, b[g*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};

      assign sum[g*BLK +: BLK] = carry[g] ? s_c1[BLK-1:0] : s_c0[BLK-1:0];
      assign carry[g+1]        = carry[g] ? s_c1[BLK]     : s_c0[BLK];
   end

   assign cout = carry[NBLK];

endmodule

module add64_scheduler (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [63:0] req0_a,
   input  logic [63:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [63:0] req1_a,
   input  logic [63:0] req1_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [63:0] rsp_sum,
   output logic        rsp_cout,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE,
      LO,
      HI,
      INC,
      RSP
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] op_a_q, op_a_d;
   logic [63:0] op_b_q, op_b_d;
   logic        id_q, id_d;
   logic [31:0] sum_lo_q, sum_lo_d;
   logic [31:0] sum_hi_q, sum_hi_d;
   logic        c_lo_q, c_lo_d;
   logic        c_hi_q, c_hi_d;
   logic        last_q, last_d;

   logic        grant0;
   logic        grant1;
   logic [31:0] adder_a;
   logic [31:0] adder_b;
   logic [31:0] adder_sum;
   logic        adder_cout;

   CSelA32 u_adder (
      .sum  (adder_sum),
      .cout (adder_cout),
      .a    (adder_a),
      .b    (adder_b)
   );

   // Round-robin grant: under contention the requester that did not own the last result wins.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == IDLE && !rst) begin
         if (req0_valid && req1_valid) begin
            grant0 = last_q;
            grant1 = ~last_q;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   always_comb begin
      adder_a = 32'h0;
      adder_b = 32'h0;
      case (state_q)
         LO: begin
            adder_a = op_a_q[31:0];
            adder_b = op_b_q[31:0];
         end
         HI: begin
            adder_a = op_a_q[63:32];
            adder_b = op_b_q[63:32];
         end
         INC: begin
            adder_a = sum_hi_q;
            adder_b = 32'h1;
         end
         default: begin
            adder_a = 32'h0;
            adder_b = 32'h0;
         end
      endcase
   end

   // A high-half carry and an increment carry cannot coexist, so OR-ing them gives the true carry-out.
   always_comb begin
      state_d  = state_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      id_d     = id_q;
      sum_lo_d = sum_lo_q;
      sum_hi_d = sum_hi_q;
      c_lo_d   = c_lo_q;
      c_hi_d   = c_hi_q;
      last_d   = last_q;
      case (state_q)
         IDLE: begin
            if (grant0 || grant1) begin
               op_a_d  = grant1 ? req1_a : req0_a;
               op_b_d  = grant1 ? req1_b : req0_b;
               id_d    = grant1;
               state_d = LO;
            end
         end
         LO: begin
            sum_lo_d = adder_sum;
            c_lo_d   = adder_cout;
            state_d  = HI;
         end
         HI: begin
            sum_hi_d = adder_sum;
            c_hi_d   = adder_cout;
            state_d  = c_lo_q ? INC : RSP;
         end
         INC: begin
            sum_hi_d = adder_sum;
            c_hi_d   = c_hi_q | adder_cout;
            state_d  = RSP;
         end
         RSP: begin
            if (rsp_ready) begin
               last_d  = id_q;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_a_q   <= 64'h0;
         op_b_q   <= 64'h0;
         id_q     <= 1'b0;
         sum_lo_q <= 32'h0;
         sum_hi_q <= 32'h0;
         c_lo_q   <= 1'b0;
         c_hi_q   <= 1'b0;
         last_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         id_q     <= id_d;
         sum_lo_q <= sum_lo_d;
         sum_hi_q <= sum_hi_d;
         c_lo_q   <= c_lo_d;
         c_hi_q   <= c_hi_d;
         last_q   <= last_d;
      end
   end

   assign rsp_valid = (state_q == RSP);
   assign rsp_sum   = rsp_valid ? {sum_hi_q, sum_lo_q} : 64'h0;
   assign rsp_cout  = rsp_valid & c_hi_q;
   assign rsp_id    = rsp_valid & id_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_add64_scheduler.sv
// Scoreboard bench for add64_scheduler: expected sums are queued at request accept and checked at response.

module tb_add64_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready;
   logic [63:0] req0_a, req0_b;
   logic        req1_valid, req1_ready;
   logic [63:0] req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
   logic [63:0] rsp_sum;

   typedef struct packed {
      logic        id;
      logic        cout;
      logic [63:0] sum;
   } exp_t;

   exp_t exp_q[$];
   int   grant_log[$];
   int   accept_cyc[$];
   exp_t mon_e;
   int   cycle_cnt = 0;
   int   num_checks = 0;
   int   num_pass = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt++;

   add64_scheduler dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_sum    (rsp_sum),
      .rsp_cout   (rsp_cout),
      .busy       (busy)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      num_checks++;
      if (observed === expected) num_pass++;
      else $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
   endtask

   function automatic exp_t model(input logic id, input logic [63:0] a, input logic [63:0] b);
      logic [64:0] s;
      s = {1'b0, a} + {1'b0, b};
      return {id, s[64], s[63:0]};
   endfunction

   function automatic int modelLatency(input logic [63:0] a, input logic [63:0] b);
      logic [32:0] lo;
      lo = {1'b0, a[31:0]} + {1'b0, b[31:0]};
      return lo[32] ? 4 : 3;
   endfunction

   // Scoreboard monitor: push on request handshake, pop and compare on response handshake.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (req0_ready || req1_ready) begin
            checkOutput("ready_excl", {63'b0, req0_ready & req1_ready}, 64'd0);
            checkOutput("ready_idle", {63'b0, busy}, 64'd0);
            if (req0_ready && req0_valid) begin
               exp_q.push_back(model(1'b0, req0_a, req0_b));
               grant_log.push_back(0);
               accept_cyc.push_back(cycle_cnt);
            end
            if (req1_ready && req1_valid) begin
               exp_q.push_back(model(1'b1, req1_a, req1_b));
               grant_log.push_back(1);
               accept_cyc.push_back(cycle_cnt);
            end
         end
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("rsp_unexpected", {63'b0, rsp_valid}, 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               checkOutput("sb_sum", rsp_sum, mon_e.sum);
               checkOutput("sb_cout", {63'b0, rsp_cout}, {63'b0, mon_e.cout});
               checkOutput("sb_id", {63'b0, rsp_id}, {63'b0, mon_e.id});
            end
         end
      end
   end

   task automatic applyStimulus(input logic id, input logic [63:0] a, input logic [63:0] b);
      bit ok;
      ok = 1'b0;
      @(posedge clk);
      #1;
      if (id) begin
         req1_a = a; req1_b = b; req1_valid = 1'b1;
      end else begin
         req0_a = a; req0_b = b; req0_valid = 1'b1;
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (id ? req1_ready : req0_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) @(posedge clk);
      else checkOutput("accept_timeout", {63'b0, ok}, 64'd1);
      #1;
      if (id) req1_valid = 1'b0;
      else req0_valid = 1'b0;
   endtask

   // Latency counts rising edges from and including the accept edge up to the first rsp_valid sample.
   task automatic checkLatency(input string tag, input int exp_lat);
      int lat;
      bit seen;
      lat = 1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk);
         lat++;
      end
      if (seen) checkOutput(tag, 64'(lat), 64'(exp_lat));
      else checkOutput({tag, "_timeout"}, {63'b0, seen}, 64'd1);
   endtask

   task automatic waitIdle();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!busy && !rsp_valid) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) checkOutput("idle_timeout", {63'b0, done}, 64'd1);
   endtask

   task automatic waitGrants(input int n);
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         if (grant_log.size() >= n) break;
      end
      #1;
      if (grant_log.size() < n) checkOutput("grant_timeout", 64'(grant_log.size()), 64'(n));
   endtask

   initial begin
      logic [63:0] ra, rb;
      logic        any_valid;

      rst = 1'b1;
      rsp_ready = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b0;
      req0_a = 64'h0; req0_b = 64'h0; req1_a = 64'h0; req1_b = 64'h0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ctl", {58'b0, rsp_valid, busy, rsp_cout, rsp_id, req0_ready, req1_ready}, 64'd0);
      checkOutput("rst_sum", rsp_sum, 64'd0);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      rst = 1'b0;

      applyStimulus(1'b0, 64'h00000000_FFFFFFFF, 64'h00000000_00000001);
      checkLatency("lat_t1", 4);
      checkOutput("t1_sum", rsp_sum, 64'h00000001_00000000);
      checkOutput("t1_id_cout", {62'b0, rsp_id, rsp_cout}, 64'd0);
      waitIdle();

      applyStimulus(1'b1, 64'h12345678_9ABCDEF0, 64'h11111111_11111111);
      checkLatency("lat_t2", 3);
      checkOutput("t2_sum", rsp_sum, 64'h23456789_ABCDF001);
      checkOutput("t2_id_cout", {62'b0, rsp_id, rsp_cout}, 64'd2);
      waitIdle();

      applyStimulus(1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF);
      checkLatency("lat_t3", 4);
      checkOutput("t3_sum", rsp_sum, 64'hFFFFFFFF_FFFFFFFE);
      checkOutput("t3_cout", {63'b0, rsp_cout}, 64'd1);
      waitIdle();

      applyStimulus(1'b1, 64'hFFFFFFFF_80000000, 64'h00000000_80000000);
      checkLatency("lat_t4", 4);
      checkOutput("t4_sum", rsp_sum, 64'd0);
      checkOutput("t4_cout", {63'b0, rsp_cout}, 64'd1);
      waitIdle();

      for (int i = 0; i < 6; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         applyStimulus(i[0], ra, rb);
         checkLatency("lat_rand", modelLatency(ra, rb));
         waitIdle();
      end

      // Contention from reset: req0 carries in its low half, req1 does not.
      @(posedge clk);
      #1;
      rst = 1'b1;
      grant_log.delete();
      accept_cyc.delete();
      req0_a = 64'h00000000_FFFFFFFF; req0_b = 64'h1;
      req1_a = 64'h5;                 req1_b = 64'h6;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      waitGrants(4);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (grant_log.size() >= 4) begin
         checkOutput("rr_order", {60'b0, grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]}, 64'h5);
         checkOutput("rr_gap0", 64'(accept_cyc[1] - accept_cyc[0]), 64'd5);
         checkOutput("rr_gap1", 64'(accept_cyc[2] - accept_cyc[1]), 64'd4);
         checkOutput("rr_gap2", 64'(accept_cyc[3] - accept_cyc[2]), 64'd5);
      end
      waitIdle();

      // Backpressure with req0 waiting: the result must stay frozen and nobody may be granted.
      rsp_ready = 1'b0;
      applyStimulus(1'b1, 64'h01234567_89ABCDEF, 64'h11111111_11111111);
      req0_a = 64'h10; req0_b = 64'h20; req0_valid = 1'b1;
      checkLatency("lat_bp", 3);
      for (int i = 0; i < 6; i++) begin
         checkOutput("bp_sum", rsp_sum, 64'h12345678_9ABCDF00);
         checkOutput("bp_ctl", {58'b0, rsp_valid, rsp_cout, rsp_id, busy, req0_ready, req1_ready}, 64'h2C);
         @(posedge clk);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_release", {62'b0, rsp_valid, req0_ready}, 64'd2);
      @(negedge clk);
      checkOutput("bp_next_accept", {62'b0, rsp_valid, req0_ready}, 64'd1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      waitIdle();

      // Reset while the high half is being computed.
      applyStimulus(1'b0, 64'h1, 64'h2);
      @(posedge clk);
      #1;
      checkOutput("hi_busy", {63'b0, busy}, 64'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst", {62'b0, busy, rsp_valid}, 64'd0);
      any_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         any_valid = any_valid | rsp_valid;
      end
      checkOutput("discarded", {63'b0, any_valid}, 64'd0);

      applyStimulus(1'b1, 64'hDEADBEEF_00000010, 64'h00000001_00000020);
      checkLatency("lat_after_rst", 3);
      checkOutput("after_rst_sum", rsp_sum, 64'hDEADBEF0_00000030);
      waitIdle();

      grant_log.delete();
      @(posedge clk);
      #1;
      req0_a = 64'h7; req0_b = 64'h8; req1_a = 64'h9; req1_b = 64'hA;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      waitGrants(1);
      req0_valid = 1'b0;
      waitGrants(2);
      req1_valid = 1'b0;
      if (grant_log.size() >= 2)
         checkOutput("post_rst_order", {62'b0, grant_log[0][0], grant_log[1][0]}, 64'd1);
      waitIdle();

      checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", num_pass, num_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
